// File: rtl/viterbi_ber_monitor.sv
// Receive-side BER monitor: auto-aligns decoded bits against reference history, then counts bits/errors.
// Optional simulation trace enabled by defining BER_MON_DISPLAY_EN.
module viterbi_ber_monitor #(
    parameter int MAX_LAT  = 64,
    parameter int LOCK_WIN = 32,
    parameter int LOSS_THR = 8,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ref_valid_i,
    input  logic                       ref_bit_i,
    input  logic                       dec_valid_i,
    input  logic                       dec_bit_i,
    input  logic                       clear_i,
    output logic                       locked_o,
    output logic [$clog2(MAX_LAT)-1:0] latency_o,
    output logic [CNT_W-1:0]           bit_ct_o,
    output logic [CNT_W-1:0]           err_ct_o,
    output logic                       sat_o
);

    localparam int LAT_W = $clog2(MAX_LAT);
    localparam int RUN_W = $clog2(LOCK_WIN + 1);
    localparam int WE_W  = $clog2(LOSS_THR + 1);

    typedef enum logic [1:0] {IDLE, SEARCH, LOCK} state_t;

    state_t             state, state_n;
    logic [MAX_LAT-1:0] hist;
    logic [LAT_W-1:0]   cand, cand_n, cand_inc;
    logic [RUN_W-1:0]   run, run_n;
    logic [RUN_W-1:0]   win_ct, win_ct_n;
    logic [WE_W-1:0]    win_err, win_err_n;
    logic [CNT_W-1:0]   bit_ct, bit_n, err_ct, err_n;
    logic               sat, sat_n;
    logic               match;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            hist    <= '0;
            cand    <= '0;
            run     <= '0;
            win_ct  <= '0;
            win_err <= '0;
            bit_ct  <= '0;
            err_ct  <= '0;
            sat     <= 1'b0;
        end else begin
            state   <= state_n;
            cand    <= cand_n;
            run     <= run_n;
            win_ct  <= win_ct_n;
            win_err <= win_err_n;
            bit_ct  <= bit_n;
            err_ct  <= err_n;
            sat     <= sat_n;
            if (ref_valid_i)
                hist <= {hist[MAX_LAT-2:0], ref_bit_i};
        end
    end

    // Compare uses pre-edge history, so a same-edge shift never affects the match.
    assign match    = (dec_bit_i == hist[cand]);
    assign cand_inc = (cand == LAT_W'(MAX_LAT - 1)) ? '0 : cand + LAT_W'(1);

    always_comb begin
        state_n   = state;
        cand_n    = cand;
        run_n     = run;
        win_ct_n  = win_ct;
        win_err_n = win_err;
        bit_n     = bit_ct;
        err_n     = err_ct;
        sat_n     = sat;
        if (dec_valid_i) begin
            if (state == LOCK) begin
                if (bit_ct == '1) sat_n = 1'b1;
                else              bit_n = bit_ct + CNT_W'(1);
                if (!match) begin
                    if (err_ct == '1) sat_n = 1'b1;
                    else              err_n = err_ct + CNT_W'(1);
                end
                win_ct_n  = win_ct + RUN_W'(1);
                win_err_n = win_err + WE_W'(!match);
                if (win_err_n == WE_W'(LOSS_THR)) begin
                    state_n   = SEARCH;
                    cand_n    = cand_inc;
                    run_n     = '0;
                    win_ct_n  = '0;
                    win_err_n = '0;
                end else if (win_ct_n == RUN_W'(LOCK_WIN)) begin
                    win_ct_n  = '0;
                    win_err_n = '0;
                end
            end else begin
                // IDLE evaluates its first decoded bit exactly like SEARCH.
                state_n = SEARCH;
                if (match) begin
                    run_n = run + RUN_W'(1);
                    if (run_n == RUN_W'(LOCK_WIN)) begin
                        state_n   = LOCK;
                        run_n     = '0;
                        win_ct_n  = '0;
                        win_err_n = '0;
                    end
                end else begin
                    run_n  = '0;
                    cand_n = cand_inc;
                end
            end
        end
        if (clear_i) begin
            bit_n = '0;
            err_n = '0;
            sat_n = 1'b0;
        end
    end

    assign locked_o  = (state == LOCK);
    assign latency_o = cand;
    assign bit_ct_o  = bit_ct;
    assign err_ct_o  = err_ct;
    assign sat_o     = sat;

`ifdef BER_MON_DISPLAY_EN
    always_ff @(posedge clk) begin
        if (rst && dec_valid_i) begin
            if (state != LOCK && state_n == LOCK)
                $display("lock lat=%0d", cand);
            if (state == LOCK && state_n == SEARCH)
                $display("loss of lock lat=%0d", cand);
            if (state == LOCK && !match)
                $display("mismatch bit_ct=%0d err_ct=%0d", bit_n, err_n);
        end
    end
`else
`endif

endmodule

// File: tb/tb_viterbi_ber_monitor.sv
// Scoreboard bench for viterbi_ber_monitor: 16-bit and 8-bit counter instances share one stimulus stream.
module tb_viterbi_ber_monitor;

    localparam int DLY      = 10;
    localparam int LOCK_WIN = 32;
    localparam int LOSS_THR = 8;
    localparam int BOUND    = 64 * 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       ref_valid_i, ref_bit_i, dec_valid_i, dec_bit_i, clear_i;
    logic       locked_o, locked8;
    logic [5:0] latency_o, latency8;
    logic [15:0] bit_ct_o, err_ct_o;
    logic [7:0]  bit8, err8;
    logic       sat_o, sat8;

    always #5 clk = ~clk;

    viterbi_ber_monitor dut (
        .clk(clk), .rst(rst), .ref_valid_i(ref_valid_i), .ref_bit_i(ref_bit_i),
        .dec_valid_i(dec_valid_i), .dec_bit_i(dec_bit_i), .clear_i(clear_i),
        .locked_o(locked_o), .latency_o(latency_o), .bit_ct_o(bit_ct_o),
        .err_ct_o(err_ct_o), .sat_o(sat_o)
    );

    viterbi_ber_monitor #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .ref_valid_i(ref_valid_i), .ref_bit_i(ref_bit_i),
        .dec_valid_i(dec_valid_i), .dec_bit_i(dec_bit_i), .clear_i(clear_i),
        .locked_o(locked8), .latency_o(latency8), .bit_ct_o(bit8),
        .err_ct_o(err8), .sat_o(sat8)
    );

    typedef struct {
        bit lk;
        int lat;
        int b16;
        int e16;
        int b8;
        int e8;
        bit s16;
        bit s8;
    } exp_t;

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    logic [63:0] tb_sh = '0;
    bit          tb_locked = 0;
    int          win_n = 0, win_e = 0;
    int          m_b16 = 0, m_e16 = 0, m_b8 = 0, m_e8 = 0;
    bit          m_s16 = 0, m_s8 = 0;

    task automatic model_reset();
        tb_sh = '0; tb_locked = 0; win_n = 0; win_e = 0;
        m_b16 = 0; m_e16 = 0; m_b8 = 0; m_e8 = 0; m_s16 = 0; m_s8 = 0;
        sbq.delete();
    endtask

    // One decoded bit; dec_bit is the reference delayed DLY cycles, optionally inverted.
    task automatic step(input bit inv, input bit clr);
        exp_t e, o;
        bit   r, was_locked;
        r = 1'($urandom_range(0, 1));
        ref_valid_i = 1'b1; ref_bit_i = r;
        dec_valid_i = 1'b1; dec_bit_i = tb_sh[DLY-1] ^ inv;
        clear_i = clr;
        was_locked = tb_locked;
        if (tb_locked) begin
            if (m_b16 == 65535) m_s16 = 1; else m_b16++;
            if (m_b8 == 255) m_s8 = 1; else m_b8++;
            if (inv) begin
                if (m_e16 == 65535) m_s16 = 1; else m_e16++;
                if (m_e8 == 255) m_s8 = 1; else m_e8++;
            end
            win_n++;
            win_e += int'(inv);
            if (win_e == LOSS_THR) begin
                tb_locked = 0; win_n = 0; win_e = 0;
            end else if (win_n == LOCK_WIN) begin
                win_n = 0; win_e = 0;
            end
        end
        if (clr) begin
            m_b16 = 0; m_e16 = 0; m_b8 = 0; m_e8 = 0; m_s16 = 0; m_s8 = 0;
        end
        if (was_locked) begin
            e.lk = tb_locked; e.lat = tb_locked ? DLY - 1 : DLY;
            e.b16 = m_b16; e.e16 = m_e16; e.b8 = m_b8; e.e8 = m_e8;
            e.s16 = m_s16; e.s8 = m_s8;
            sbq.push_back(e);
        end
        @(posedge clk);
        tb_sh = {tb_sh[62:0], r};
        #1;
        clear_i = 1'b0;
        while (sbq.size() > 0) begin
            o = sbq.pop_front();
            checks++; if (locked_o !== o.lk) begin errors++; $display("FAIL sb_locked: got %0b want %0b", locked_o, o.lk); end
            checks++; if (locked8 !== o.lk) begin errors++; $display("FAIL sb_locked8: got %0b want %0b", locked8, o.lk); end
            checks++; if (latency_o !== 6'(o.lat)) begin errors++; $display("FAIL sb_latency: got %0d want %0d", latency_o, o.lat); end
            checks++; if (bit_ct_o !== 16'(o.b16)) begin errors++; $display("FAIL sb_bit_ct: got %0d want %0d", bit_ct_o, o.b16); end
            checks++; if (err_ct_o !== 16'(o.e16)) begin errors++; $display("FAIL sb_err_ct: got %0d want %0d", err_ct_o, o.e16); end
            checks++; if (bit8 !== 8'(o.b8)) begin errors++; $display("FAIL sb_bit_ct8: got %0d want %0d", bit8, o.b8); end
            checks++; if (err8 !== 8'(o.e8)) begin errors++; $display("FAIL sb_err_ct8: got %0d want %0d", err8, o.e8); end
            checks++; if (sat_o !== o.s16) begin errors++; $display("FAIL sb_sat: got %0b want %0b", sat_o, o.s16); end
            checks++; if (sat8 !== o.s8) begin errors++; $display("FAIL sb_sat8: got %0b want %0b", sat8, o.s8); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; ref_valid_i = 0; ref_bit_i = 0; dec_valid_i = 0; dec_bit_i = 0; clear_i = 0;
        model_reset();
        #12;
        checks++; if ({locked_o, latency_o, bit_ct_o, err_ct_o, sat_o} !== '0) begin
            errors++; $display("FAIL reset_outputs: lk=%0b lat=%0d bit=%0d err=%0d sat=%0b want all 0",
                               locked_o, latency_o, bit_ct_o, err_ct_o, sat_o); end
        checks++; if ({locked8, latency8, bit8, err8, sat8} !== '0) begin
            errors++; $display("FAIL reset_outputs8: lk=%0b lat=%0d bit=%0d err=%0d sat=%0b want all 0",
                               locked8, latency8, bit8, err8, sat8); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_acquire(input string tag);
        int n = 0;
        while (locked_o !== 1'b1 && n < BOUND) begin
            step(0, 0);
            n++;
        end
        checks++; if (locked_o !== 1'b1) begin errors++; $display("FAIL %s_lock: locked_o=%0b want 1 within %0d bits", tag, locked_o, BOUND); end
        checks++; if (latency_o !== 6'(DLY - 1)) begin errors++; $display("FAIL %s_latency: got %0d want %0d", tag, latency_o, DLY - 1); end
        checks++; if (bit_ct_o !== 16'(m_b16)) begin errors++; $display("FAIL %s_bit_hold: got %0d want %0d", tag, bit_ct_o, m_b16); end
        checks++; if (err_ct_o !== 16'(m_e16)) begin errors++; $display("FAIL %s_err_hold: got %0d want %0d", tag, err_ct_o, m_e16); end
        tb_locked = 1; win_n = 0; win_e = 0;
        for (int i = 0; i < 50; i++) step(0, 0);
    endtask

    task automatic test_sparse_errors();
        int e0;
        e0 = m_e16;
        for (int i = 0; i < 1000; i++) step(i % 100 == 99, 0);
        checks++; if (err_ct_o !== 16'(e0 + 10)) begin errors++; $display("FAIL sparse_err_ct: got %0d want %0d", err_ct_o, e0 + 10); end
        checks++; if (locked_o !== 1'b1) begin errors++; $display("FAIL sparse_locked: got %0b want 1", locked_o); end
    endtask

    task automatic test_valid_low_hold();
        int b0, e0;
        b0 = m_b16; e0 = m_e16;
        ref_valid_i = 0; dec_valid_i = 0;
        for (int i = 0; i < 5; i++) begin
            dec_bit_i = ~dec_bit_i; ref_bit_i = ~ref_bit_i;
            @(posedge clk); #1;
        end
        checks++; if (bit_ct_o !== 16'(b0) || err_ct_o !== 16'(e0) || locked_o !== 1'b1) begin
            errors++; $display("FAIL valid_low_hold: bit=%0d err=%0d lk=%0b want %0d %0d 1", bit_ct_o, err_ct_o, locked_o, b0, e0); end
    endtask

    task automatic test_loss_relock();
        int b0, e0;
        while (win_n != 0) step(0, 0);
        b0 = m_b16; e0 = m_e16;
        for (int i = 0; i < LOSS_THR; i++) step(1, 0);
        checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL loss_locked: got %0b want 0", locked_o); end
        checks++; if (latency_o !== 6'(DLY)) begin errors++; $display("FAIL loss_latency: got %0d want %0d", latency_o, DLY); end
        for (int i = 0; i < 8; i++) step(0, 0);
        checks++; if (bit_ct_o !== 16'(b0 + LOSS_THR) || err_ct_o !== 16'(e0 + LOSS_THR)) begin
            errors++; $display("FAIL loss_counters_hold: bit=%0d err=%0d want %0d %0d", bit_ct_o, err_ct_o, b0 + LOSS_THR, e0 + LOSS_THR); end
        test_acquire("relock");
    endtask

    task automatic test_saturate();
        step(0, 1);
        for (int i = 0; i < 300; i++) step(0, 0);
        checks++; if (bit8 !== 8'd255) begin errors++; $display("FAIL sat_bit_ct8: got %0d want 255", bit8); end
        checks++; if (sat8 !== 1'b1) begin errors++; $display("FAIL sat_flag8: got %0b want 1", sat8); end
        checks++; if (bit_ct_o !== 16'd300 || sat_o !== 1'b0) begin
            errors++; $display("FAIL sat_wide: bit=%0d sat=%0b want 300 0", bit_ct_o, sat_o); end
        step(0, 1);
        checks++; if (bit8 !== 8'd0 || sat8 !== 1'b0 || locked8 !== 1'b1) begin
            errors++; $display("FAIL sat_clear: bit=%0d sat=%0b lk=%0b want 0 0 1", bit8, sat8, locked8); end
    endtask

    task automatic test_clear_mismatch();
        for (int i = 0; i < 5; i++) step(0, 0);
        step(1, 1);
        checks++; if (err_ct_o !== 16'd0 || bit_ct_o !== 16'd0) begin
            errors++; $display("FAIL clear_vs_mismatch: err=%0d bit=%0d want 0 0", err_ct_o, bit_ct_o); end
    endtask

    task automatic test_reset_midlock();
        for (int i = 0; i < 20; i++) step(i == 7, 0);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checks++; if ({locked_o, latency_o, bit_ct_o, err_ct_o, sat_o} !== '0) begin
            errors++; $display("FAIL midlock_reset: lk=%0b lat=%0d bit=%0d err=%0d sat=%0b want all 0",
                               locked_o, latency_o, bit_ct_o, err_ct_o, sat_o); end
        checks++; if ({locked8, latency8, bit8, err8, sat8} !== '0) begin
            errors++; $display("FAIL midlock_reset8: lk=%0b lat=%0d bit=%0d err=%0d sat=%0b want all 0",
                               locked8, latency8, bit8, err8, sat8); end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        test_acquire("reacquire");
    endtask

    initial begin
        test_reset();
        test_acquire("acquire");
        test_sparse_errors();
        test_valid_low_hold();
        test_loss_relock();
        test_saturate();
        test_clear_mismatch();
        test_reset_midlock();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
